// File: rtl/msk_state_collector_pkg.sv
// Shared constants and helpers for the masked AES input stage.
// Column width, share indexing and fill-counter sizing live here.
package msk_aes_pkg;

  localparam int COL_BITS  = 32;
  localparam int NCOLS_DEF = 4;
  localparam int D_DEF     = 2;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } fill_state_e;

  // Position of bit b, share s inside a share-interleaved word with d shares.
  function automatic int idx(input int b, input int s, input int d);
    return b * d + s;
  endfunction

  function automatic int cnt_width(input int ncols);
    return $clog2(ncols + 1);
  endfunction

endpackage

// File: rtl/msk_state_collector_if.sv
// Column input and state output handshakes of the masked state collector.
interface msk_state_collector_if
  import msk_aes_pkg::*;
#(
  parameter int d     = D_DEF,
  parameter int NCOLS = NCOLS_DEF
);

  logic                            in_valid;
  logic                            in_ready;
  logic [COL_BITS*d-1:0]           in_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [COL_BITS*NCOLS*d-1:0]     out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/msk_state_collector_col_stage.sv
// One masked column register: a per-bit shift-in/hold mux feeding a
// synchronously reset flop; each bit only ever sees its own share.
module msk_col_stage #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         syn_rst,
  input  logic         shift_en,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] q
);

  logic [W-1:0] nxt_s;

  // Independent 2:1 mux per share bit; select is handshake-derived only.
  always_comb begin
    nxt_s = q;
    for (int i = 0; i < W; i++) begin
      if (shift_en) begin
        nxt_s[i] = d_in[i];
      end else begin
        nxt_s[i] = q[i];
      end
    end
  end

  // Column storage flop.
  always_ff @(posedge clk) begin
    if (syn_rst) begin
      q <= {W{1'b0}};
    end else begin
      q <= nxt_s;
    end
  end

endmodule

// File: rtl/msk_state_collector.sv
// Assembles NCOLS masked 32-bit columns into one masked AES state.
// Counter and handshake logic plus a chain of column stages.
module msk_state_collector
  import msk_aes_pkg::*;
#(
  parameter int d     = D_DEF,
  parameter int NCOLS = NCOLS_DEF
) (
  input  logic                  clk,
  input  logic                  syn_rst,
  msk_state_collector_if.slave  bus
);

  localparam int W     = COL_BITS * d;
  localparam int CNT_W = cnt_width(NCOLS);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NCOLS);

  fill_state_e       state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              accept_s;
  logic              release_s;
  logic              shift_s;
  logic [W-1:0]      col_s      [NCOLS];
  logic [W-1:0]      stage_in_s [NCOLS];

  // out_ready feeds in_ready directly so a full state can be swapped in one edge.
  assign bus.in_ready  = (cnt_r != CNT_FULL) | bus.out_ready;
  assign bus.out_valid = (state_r == ST_FULL);
  assign accept_s      = bus.in_valid & bus.in_ready;
  assign release_s     = bus.out_valid & bus.out_ready;
  assign shift_s       = accept_s & ~syn_rst;

  // Fill counter and FILL/FULL state; reset dominates any handshake.
  always_ff @(posedge clk) begin
    if (syn_rst) begin
      cnt_r   <= CNT_ZERO;
      state_r <= ST_FILL;
    end else begin
      case ({accept_s, release_s})
        2'b10: begin
          cnt_r   <= cnt_r + CNT_ONE;
          state_r <= ((cnt_r + CNT_ONE) == CNT_FULL) ? ST_FULL : ST_FILL;
        end
        2'b01: begin
          cnt_r   <= CNT_ZERO;
          state_r <= ST_FILL;
        end
        2'b11: begin
          cnt_r   <= CNT_ONE;
          state_r <= (CNT_ONE == CNT_FULL) ? ST_FULL : ST_FILL;
        end
        default: begin
          cnt_r   <= cnt_r;
          state_r <= state_r;
        end
      endcase
    end
  end

  // Shift chain: newest column enters at the top, oldest ends in column 0.
  for (genvar k = 0; k < NCOLS; k++) begin : g_stage
    if (k == NCOLS - 1) begin : g_head
      assign stage_in_s[k] = bus.in_data;
    end else begin : g_link
      assign stage_in_s[k] = col_s[k+1];
    end

    (* keep_hierarchy = "yes" *)
    msk_col_stage #(
      .W (W)
    ) u_stage (
      .clk      (clk),
      .syn_rst  (syn_rst),
      .shift_en (shift_s),
      .d_in     (stage_in_s[k]),
      .q        (col_s[k])
    );

    assign bus.out_data[W*k +: W] = col_s[k];
  end

endmodule
